// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared TLC widths, default phase durations and timer state encoding
package tlc_pkg;

    localparam int TLC_CNT_W = 5;

    // Default phase durations in count ticks
    localparam int RED_T = 28;
    localparam int YEL_T = 3;
    localparam int GRN_T = 28;

    // Timer state encoding, also decoded by the controller
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/tlc_prescaler.sv
// rtl/tlc_prescaler.sv - clk-cycle prescaler producing one-cycle count ticks
module tlc_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PRE_W    = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    logic [PRE_W-1:0] pre_q;

    // A tick fires on the last cycle of each prescale window while enabled
    assign tick_o = en_i && (pre_q == PRE_W'(PRESCALE - 1));

    // Prescale counter: clear wins over enable, wraps to zero on a tick, frozen otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (clr_i) begin
            pre_q <= '0;
        end else if (en_i) begin
            if (tick_o) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/tlc_timer.sv
// rtl/tlc_timer.sv - TLC phase timer; TLC_TIMER_PAUSE_EN adds the hold input
module tlc_timer
    import tlc_pkg::*;
#(
    parameter int CNT_W    = TLC_CNT_W,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_rst,
    input  logic [CNT_W-1:0] wait_cnt,
`ifdef TLC_TIMER_PAUSE_EN
    input  logic             hold,
`endif
    output logic             cntr_done,
    output logic [CNT_W-1:0] cnt_val
);

    localparam int PRE_W = $clog2(PRESCALE + 1);

    tmr_state_e       state_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             hold_act;
    logic             cnt_en;
    logic             tick;

`ifdef TLC_TIMER_PAUSE_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // Only a running, unfrozen countdown advances the prescaler
    assign cnt_en = (state_q == COUNT) && !hold_act;

    tlc_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_rst),
        .en_i   (cnt_en),
        .tick_o (tick)
    );

    // Timer FSM: load beats tick; remaining saturates at zero and done is held until reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else if (cnt_rst) begin
            rem_q   <= wait_cnt;
            state_q <= (wait_cnt == '0) ? DONE : COUNT;
            done_q  <= (wait_cnt == '0);
        end else if (tick) begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
            end
        end
    end

    assign cntr_done = done_q;
    assign cnt_val   = rem_q;

endmodule
